// File: rtl/uart_tx_merge.sv
// -----------------------------------------------------------------------------
// uart_tx_merge : N-channel UART TX merger with whole-frame round-robin grant
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module uart_tx_merge #(
  parameter int NUM_CH     = 2,
  parameter int CLK_FREQ   = 32000000,
  parameter int BAUDRATE   = 1000000,
  parameter int FRAME_BITS = 10,
  parameter     MODE       = "MUX"
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] txd_i,
  output logic              txd_o,
  output logic              active_o,
  output logic [NUM_CH-1:0] grant_o,
  output logic [NUM_CH-1:0] drop_o
);

  localparam int BIT_CYCLES   = CLK_FREQ / BAUDRATE;
  localparam int FRAME_CYCLES = FRAME_BITS * BIT_CYCLES;
  localparam int CW           = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] TRACK = CW'(FRAME_CYCLES - BIT_CYCLES / 2 - 1);
  localparam int PW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam bit AND_MODE     = (MODE == "AND");

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] at_zero;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pick_oh;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     pick;
  logic              found;
  logic              owner_zero;
  logic              owner_bit;
  logic              pick_bit;
  int                idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= txd_i;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Only a fall seen by an idle tracker is a frame start; data-bit falls are ignored.
  assign start = AND_MODE ? '0 : ((prev & ~sync2) & ~busy);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_trk
      logic          busy_r;
      logic [CW-1:0] cnt_r;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          busy_r <= 1'b0;
          cnt_r  <= '0;
        end else if (start[i]) begin
          busy_r <= 1'b1;
          cnt_r  <= TRACK;
        end else if (busy_r) begin
          if (cnt_r == '0) begin
            busy_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
      end

      assign busy[i]    = busy_r;
      assign at_zero[i] = busy_r && (cnt_r == '0);
    end
  endgenerate

  assign req        = start | pending;
  assign owner_zero = |(grant_o & at_zero);
  assign owner_bit  = ~|(grant_o & ~sync2);
  assign pick_bit   = ~|(pick_oh & ~sync2);

  always_comb begin
    found   = 1'b0;
    pick_oh = '0;
    pick    = '0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && req[idx]) begin
        found        = 1'b1;
        pick_oh[idx] = 1'b1;
        pick         = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ptr      <= '0;
      txd_o    <= 1'b1;
      active_o <= 1'b0;
      grant_o  <= '0;
      drop_o   <= '0;
      pending  <= '0;
    end else if (AND_MODE) begin
      txd_o <= &sync2;
    end else begin
      case (state)
        IDLE: begin
          pending <= '0;
          drop_o  <= req & ~pick_oh;
          if (found) begin
            state    <= LOCK;
            grant_o  <= pick_oh;
            active_o <= 1'b1;
            ptr      <= PW'((int'(pick) + 1) % NUM_CH);
            txd_o    <= pick_bit;
          end else begin
            txd_o <= 1'b1;
          end
        end
        LOCK: begin
          txd_o <= owner_bit;
          if (owner_zero) begin
            // Starts in the release cycle are carried into the next IDLE cycle.
            state    <= IDLE;
            grant_o  <= '0;
            active_o <= 1'b0;
            drop_o   <= '0;
            pending  <= start & ~grant_o;
          end else begin
            drop_o  <= start & ~grant_o;
            pending <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_merge.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_merge : directed frame vectors against MUX and AND instances
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_merge;

  localparam int BITC = 32;
  localparam int FRC  = 320;
  localparam int HMAX = 1024;

  logic       clk;
  logic       rst;
  logic [1:0] txd;
  logic       txd_m, act_m;
  logic [1:0] gnt_m, drop_m;
  logic       txd_a, act_a;
  logic [1:0] gnt_a, drop_a;

  int n_cmp;
  int n_err;

  int         fr_ch [4];
  int         fr_s  [4];
  logic [7:0] fr_b  [4];
  int         nfr;
  int         rst_at;

  logic       hist_txd  [HMAX];
  logic       hist_and  [HMAX];
  logic       hist_act  [HMAX];
  logic       hist_side [HMAX];
  logic [1:0] hist_gnt  [HMAX];
  logic [1:0] hist_drop [HMAX];

  uart_tx_merge #(
    .NUM_CH(2), .CLK_FREQ(32000000), .BAUDRATE(1000000), .FRAME_BITS(10), .MODE("MUX")
  ) dut (
    .clk_i(clk), .rst_i(rst), .txd_i(txd),
    .txd_o(txd_m), .active_o(act_m), .grant_o(gnt_m), .drop_o(drop_m)
  );

  uart_tx_merge #(
    .NUM_CH(2), .CLK_FREQ(32000000), .BAUDRATE(1000000), .FRAME_BITS(10), .MODE("AND")
  ) dut_and (
    .clk_i(clk), .rst_i(rst), .txd_i(txd),
    .txd_o(txd_a), .active_o(act_a), .grant_o(gnt_a), .drop_o(drop_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level driven on channel ch, d cycles into the current window.
  function automatic logic wave(int ch, int d);
    logic v;
    int   k;
    v = 1'b1;
    for (int i = 0; i < nfr; i++) begin
      if (fr_ch[i] == ch && d >= fr_s[i] && d < fr_s[i] + FRC) begin
        k = (d - fr_s[i]) / BITC;
        if (k == 0) v = 1'b0;
        else if (k < 9) v = v & fr_b[i][k-1];
      end
    end
    return v;
  endfunction

  task automatic add_frame(input int ch, input int s, input logic [7:0] b);
    fr_ch[nfr] = ch;
    fr_s[nfr]  = s;
    fr_b[nfr]  = b;
    nfr++;
  endtask

  task automatic run(input int n);
    @(posedge clk);
    fork
      for (int d = 0; d < n; d++) begin
        @(posedge clk);
        #1;
        txd = {wave(1, d), wave(0, d)};
        rst = (d == rst_at);
      end
      for (int j = 0; j < n; j++) begin
        @(posedge clk);
        #2;
        hist_txd[j]  = txd_m;
        hist_and[j]  = txd_a;
        hist_act[j]  = act_m;
        hist_gnt[j]  = gnt_m;
        hist_drop[j] = drop_m;
        hist_side[j] = act_a | (|gnt_a) | (|drop_a);
      end
    join
    rst = 1'b0;
  endtask

  function automatic int txd_errs(int owner, int n);
    int e = 0;
    for (int j = 0; j < n; j++) if (hist_txd[j] !== wave(owner, j - 3)) e++;
    return e;
  endfunction

  function automatic int and_errs(int n);
    int e = 0;
    for (int j = 0; j < n; j++) if (hist_and[j] !== (wave(0, j - 3) & wave(1, j - 3))) e++;
    return e;
  endfunction

  function automatic int count_act(int n);
    int c = 0;
    for (int j = 0; j < n; j++) if (hist_act[j] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_gnt(logic [1:0] v, int n);
    int c = 0;
    for (int j = 0; j < n; j++) if (hist_gnt[j] === v) c++;
    return c;
  endfunction

  function automatic int count_drop(int ch, int n);
    int c = 0;
    for (int j = 0; j < n; j++) if (hist_drop[j][ch] !== 1'b0) c++;
    return c;
  endfunction

  function automatic int first_drop(int ch, int n);
    for (int j = 0; j < n; j++) if (hist_drop[j][ch] !== 1'b0) return j;
    return -1;
  endfunction

  function automatic int count_side(int n);
    int c = 0;
    for (int j = 0; j < n; j++) if (hist_side[j] !== 1'b0) c++;
    return c;
  endfunction

  // Mid-bit sampling of the merged line for a frame started at driver offset s.
  function automatic logic [7:0] decode(int s);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = hist_txd[s + 3 + BITC * (k + 1) + BITC / 2];
    return b;
  endfunction

  task automatic pulse_reset;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    txd    = 2'b11;
    rst    = 1'b1;
    nfr    = 0;
    rst_at = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_txd", 32'(txd_m), 32'd1);
    check("reset_active", 32'(act_m), 32'd0);
    check("reset_grant", 32'(gnt_m), 32'd0);
    check("reset_drop", 32'(drop_m), 32'd0);
    check("reset_and_txd", 32'(txd_a), 32'd1);

    // Idle line
    nfr = 0;
    run(1000);
    check("idle_txd_errs", 32'(txd_errs(0, 1000)), 32'd0);
    check("idle_active_cnt", 32'(count_act(1000)), 32'd0);
    check("idle_grant_cnt", 32'(1000 - count_gnt(2'b00, 1000)), 32'd0);
    check("idle_drop_cnt", 32'(count_drop(0, 1000) + count_drop(1, 1000)), 32'd0);

    // Single frame 0x55 on ch0
    nfr = 0;
    add_frame(0, 5, 8'h55);
    run(340);
    check("single_txd_errs", 32'(txd_errs(0, 340)), 32'd0);
    check("single_byte", 32'(decode(5)), 32'h55);
    check("single_pre_grant", 32'(hist_gnt[7]), 32'd0);
    check("single_grant", 32'(hist_gnt[8]), 32'b01);
    check("single_grant_cnt", 32'(count_gnt(2'b01, 340)), 32'd304);
    check("single_active_cnt", 32'(count_act(340)), 32'd304);
    check("single_release", 32'(hist_act[312]), 32'd0);
    check("single_drop_cnt", 32'(count_drop(0, 340) + count_drop(1, 340)), 32'd0);

    // Overlap: ch1 starts 52 cycles after ch0
    nfr = 0;
    add_frame(0, 5, 8'hA5);
    add_frame(1, 57, 8'h00);
    run(400);
    check("ovl_txd_errs", 32'(txd_errs(0, 400)), 32'd0);
    check("ovl_byte", 32'(decode(5)), 32'hA5);
    check("ovl_grant_cnt", 32'(count_gnt(2'b01, 400)), 32'd304);
    check("ovl_grant1_cnt", 32'(count_gnt(2'b10, 400)), 32'd0);
    check("ovl_drop1_cnt", 32'(count_drop(1, 400)), 32'd1);
    check("ovl_drop1_at", 32'(first_drop(1, 400)), 32'd60);
    check("ovl_drop0_cnt", 32'(count_drop(0, 400)), 32'd0);
    check("ovl_and_errs", 32'(and_errs(400)), 32'd0);
    check("ovl_and_side", 32'(count_side(400)), 32'd0);

    // Simultaneous starts, pointer back at 0
    pulse_reset();
    nfr = 0;
    add_frame(0, 5, 8'h12);
    add_frame(1, 5, 8'h34);
    run(340);
    check("sim0_grant", 32'(hist_gnt[8]), 32'b01);
    check("sim0_drop", 32'(hist_drop[8]), 32'b10);
    check("sim0_drop_cnt", 32'(count_drop(0, 340) + count_drop(1, 340)), 32'd1);
    check("sim0_txd_errs", 32'(txd_errs(0, 340)), 32'd0);
    check("sim0_byte", 32'(decode(5)), 32'h12);

    nfr = 0;
    add_frame(0, 5, 8'h56);
    add_frame(1, 5, 8'h78);
    run(340);
    check("sim1_grant", 32'(hist_gnt[8]), 32'b10);
    check("sim1_drop", 32'(hist_drop[8]), 32'b01);
    check("sim1_drop_cnt", 32'(count_drop(0, 340) + count_drop(1, 340)), 32'd1);
    check("sim1_txd_errs", 32'(txd_errs(1, 340)), 32'd0);
    check("sim1_byte", 32'(decode(5)), 32'h78);

    // Back-to-back 0x41, 0x42 on ch0
    nfr = 0;
    add_frame(0, 5, 8'h41);
    add_frame(0, 325, 8'h42);
    run(660);
    check("b2b_txd_errs", 32'(txd_errs(0, 660)), 32'd0);
    check("b2b_byte0", 32'(decode(5)), 32'h41);
    check("b2b_byte1", 32'(decode(325)), 32'h42);
    check("b2b_gap", 32'(hist_act[320]), 32'd0);
    check("b2b_grant2", 32'(hist_gnt[328]), 32'b01);
    check("b2b_grant_cnt", 32'(count_gnt(2'b01, 660)), 32'd608);
    check("b2b_drop_cnt", 32'(count_drop(0, 660) + count_drop(1, 660)), 32'd0);
    check("and_before", 32'(hist_and[7]), 32'd1);
    check("and_after3", 32'(hist_and[8]), 32'd0);
    check("b2b_and_side", 32'(count_side(660)), 32'd0);

    // Reset in the middle of a ch0 frame
    nfr = 0;
    add_frame(0, 5, 8'h00);
    rst_at = 152;
    run(520);
    rst_at = -1;
    check("mid_active_pre", 32'(hist_act[152]), 32'd1);
    check("mid_txd_pre", 32'(hist_txd[152]), 32'd0);
    check("mid_txd_post", 32'(hist_txd[153]), 32'd1);
    check("mid_grant_post", 32'(hist_gnt[153]), 32'd0);
    check("mid_active_post", 32'(hist_act[153]), 32'd0);
    check("mid_drop_post", 32'(hist_drop[153]), 32'd0);
    check("mid_and_post", 32'(hist_and[153]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
